// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART TX arbiter.
//   BYTE_W      : width of one UART byte
//   arb_state_e : arbiter FSM state encoding
package uart_arb_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_SEND        = 2'd1,
        ST_WAIT_ACCEPT = 2'd2,
        ST_WAIT_DONE   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
//   req     : request vector, one bit per requester
//   rr_ptr  : index of the most recent winner (lowest priority this round)
//   winner  : first requesting index found from rr_ptr+1 upward, with wrap
//   any_req : at least one request bit is set
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned REQ_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [REQ_W-1:0]   rr_ptr,
    output logic [REQ_W-1:0]   winner,
    output logic               any_req
);

    int unsigned idx;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        // The first hit wins; later slots in the walk are ignored.
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = (32'(rr_ptr) + off) % NUM_REQ;
            if (!any_req && req[idx[REQ_W-1:0]]) begin
                winner  = idx[REQ_W-1:0];
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte-stream requesters.
// Round-robin arbitration with packet lock: a grant is held until the holder's
// last byte, MAX_BURST bytes, or HOLD_TIMEOUT idle cycles mid-packet.
//   clk, rst     : clock, synchronous active-high reset
//   req_valid    : per-requester byte valid
//   req_data     : byte for requester i at [8i+7:8i]
//   req_last     : final byte of a packet (qualified by valid)
//   req_ready    : one-hot byte-accept strobe
//   tx_data      : byte to the UART TX core
//   tx_wr        : one-cycle write strobe to the TX core
//   tx_busy      : TX core is shifting a frame
//   grant_active : a requester holds the grant
//   grant_id     : index of the holder, valid while grant_active
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned HOLD_TIMEOUT = 1000,
    parameter int unsigned REQ_W        = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      tx_wr,
    input  logic                      tx_busy,
    output logic                      grant_active,
    output logic [REQ_W-1:0]          grant_id
);

    localparam logic [7:0]  BURST_LIM = 8'(MAX_BURST);
    localparam logic [15:0] IDLE_LIM  = 16'(HOLD_TIMEOUT - 1);

    arb_state_e         state_q, state_d;
    logic [REQ_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [REQ_W-1:0]   grant_id_q, grant_id_d;
    logic               grant_active_q, grant_active_d;
    logic [7:0]         byte_cnt_q, byte_cnt_d;
    logic [15:0]        idle_cnt_q, idle_cnt_d;
    logic               last_flag_q, last_flag_d;
    logic [BYTE_W-1:0]  tx_data_q, tx_data_d;

    logic [REQ_W-1:0]   pick_id;
    logic               any_req;
    logic [BYTE_W-1:0]  data_arr [NUM_REQ];
    logic               g_valid;
    logic               g_last;
    logic [BYTE_W-1:0]  g_data;
    logic               xfer;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .REQ_W   (REQ_W)
    ) u_rr_pick (
        .req     (req_valid),
        .rr_ptr  (rr_ptr_q),
        .winner  (pick_id),
        .any_req (any_req)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[BYTE_W*i +: BYTE_W];
        end
    end

    assign g_valid = req_valid[grant_id_q];
    assign g_last  = req_last[grant_id_q];
    assign g_data  = data_arr[grant_id_q];
    // A busy transmitter stalls the transfer even with valid high.
    assign xfer    = (state_q == ST_SEND) && g_valid && !tx_busy;

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_id_d     = grant_id_q;
        grant_active_d = grant_active_q;
        byte_cnt_d     = byte_cnt_q;
        idle_cnt_d     = idle_cnt_q;
        last_flag_d    = last_flag_q;
        tx_data_d      = tx_data_q;
        req_ready      = '0;
        tx_wr          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_id_d     = pick_id;
                    grant_active_d = 1'b1;
                    byte_cnt_d     = '0;
                    idle_cnt_d     = '0;
                    state_d        = ST_SEND;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    req_ready[grant_id_q] = 1'b1;
                    tx_wr                 = 1'b1;
                    tx_data_d             = g_data;
                    byte_cnt_d            = byte_cnt_q + 8'd1;
                    last_flag_d           = g_last;
                    idle_cnt_d            = '0;
                    state_d               = ST_WAIT_ACCEPT;
                end else if (!g_valid) begin
                    if (idle_cnt_q >= IDLE_LIM) begin
                        state_d        = ST_IDLE;
                        rr_ptr_d       = grant_id_q;
                        grant_active_d = 1'b0;
                    end else if (idle_cnt_q != 16'hFFFF) begin
                        idle_cnt_d = idle_cnt_q + 16'd1;
                    end
                end
            end
            ST_WAIT_ACCEPT: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_flag_q || (byte_cnt_q == BURST_LIM)) begin
                        // Releasing holder becomes lowest priority next round.
                        state_d        = ST_IDLE;
                        rr_ptr_d       = grant_id_q;
                        grant_active_d = 1'b0;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= REQ_W'(NUM_REQ - 1);
            grant_id_q     <= '0;
            grant_active_q <= 1'b0;
            byte_cnt_q     <= '0;
            idle_cnt_q     <= '0;
            last_flag_q    <= 1'b0;
            tx_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_id_q     <= grant_id_d;
            grant_active_q <= grant_active_d;
            byte_cnt_q     <= byte_cnt_d;
            idle_cnt_q     <= idle_cnt_d;
            last_flag_q    <= last_flag_d;
            tx_data_q      <= tx_data_d;
        end
    end

    // The write strobe cycle drives the live byte; otherwise hold the last one.
    assign tx_data      = xfer ? g_data : tx_data_q;
    assign grant_active = grant_active_q;
    assign grant_id     = grant_id_q;

endmodule
